// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: registered round-robin grant held for the whole cycle,
// plus a per-access watchdog that converts a stalled slave into a one-cycle err.
module wb_master_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic [31:0]         m0_adr,
   input  logic [3:0]          m0_sel,
   input  logic                m0_we,
   input  logic [31:0]         m0_dat_i,
   input  logic                m0_cyc,
   input  logic                m0_stb,
   output logic [31:0]         m0_dat_o,
   output logic                m0_ack,
   output logic                m0_err,
   input  logic [31:0]         m1_adr,
   input  logic [3:0]          m1_sel,
   input  logic                m1_we,
   input  logic [31:0]         m1_dat_i,
   input  logic                m1_cyc,
   input  logic                m1_stb,
   output logic [31:0]         m1_dat_o,
   output logic                m1_ack,
   output logic                m1_err,
   output logic [31:0]         s_adr,
   output logic [3:0]          s_sel,
   output logic                s_we,
   output logic [31:0]         s_dat_o,
   output logic                s_cyc,
   output logic                s_stb,
   input  logic [31:0]         s_dat_i,
   input  logic                s_ack,
   output logic [1:0]          grant,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t              r_state, w_state_nxt, w_pick;
   logic                r_last;
   logic [15:0]         r_wdog;
   logic [ERRCNT_W-1:0] r_err_count;
   logic                w_own0, w_own1, w_owner_stb, w_stall, w_tmo;

   // Round-robin pick: on contention the master that did not own the bus last wins.
   always_comb begin
      w_pick = IDLE;
      if (m0_cyc && m1_cyc) w_pick = r_last ? OWN0 : OWN1;
      else if (m0_cyc)      w_pick = OWN0;
      else if (m1_cyc)      w_pick = OWN1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         OWN0:    if (!m0_cyc) w_state_nxt = w_pick;
         OWN1:    if (!m1_cyc) w_state_nxt = w_pick;
         default: w_state_nxt = w_pick;
      endcase
   end

   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);

   always_comb begin
      s_adr   = '0;
      s_sel   = '0;
      s_we    = 1'b0;
      s_dat_o = '0;
      s_cyc   = 1'b0;
      if (w_own0) begin
         s_adr   = m0_adr;
         s_sel   = m0_sel;
         s_we    = m0_we;
         s_dat_o = m0_dat_i;
         s_cyc   = m0_cyc;
      end else if (w_own1) begin
         s_adr   = m1_adr;
         s_sel   = m1_sel;
         s_we    = m1_we;
         s_dat_o = m1_dat_i;
         s_cyc   = m1_cyc;
      end
   end

   // Stall detection uses the raw owner strobe so the timeout kill of s_stb cannot loop back.
   assign w_owner_stb = (w_own0 & m0_stb) | (w_own1 & m1_stb);
   assign w_stall     = s_cyc & w_owner_stb & ~s_ack;
   assign w_tmo       = (TIMEOUT != 0) && w_stall && (r_wdog == TMO);
   assign s_stb       = w_owner_stb & ~w_tmo;

   assign m0_ack    = s_ack & w_own0;
   assign m1_ack    = s_ack & w_own1;
   assign m0_err    = w_tmo & w_own0;
   assign m1_err    = w_tmo & w_own1;
   assign m0_dat_o  = s_dat_i;
   assign m1_dat_o  = s_dat_i;
   assign grant     = r_state;
   assign err_count = r_err_count;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state     <= IDLE;
         r_last      <= 1'b1;
         r_wdog      <= '0;
         r_err_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == OWN0) r_last <= 1'b0;
         if (w_state_nxt == OWN1) r_last <= 1'b1;
         if (!w_stall || (w_state_nxt != r_state) || (TIMEOUT == 0) || w_tmo)
            r_wdog <= '0;
         else
            r_wdog <= r_wdog + 16'd1;
         if (w_tmo && (r_err_count != '1))
            r_err_count <= r_err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (TIMEOUT=4): grant, hold, handover, routing, watchdog.
module tb_wb_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
   logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
   logic [31:0] s_adr, s_dat_o, s_dat_i;
   logic        s_we, s_cyc, s_stb, s_ack;
   logic [1:0]  grant;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_errors = 0;

   wb_master_arbiter #(.TIMEOUT(4), .ERRCNT_W(8)) dut (
      .clk(clk), .rst_b(rst_b),
      .m0_adr(m0_adr), .m0_sel(m0_sel), .m0_we(m0_we), .m0_dat_i(m0_dat_i),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_adr(m1_adr), .m1_sel(m1_sel), .m1_we(m1_we), .m1_dat_i(m1_dat_i),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_adr(s_adr), .s_sel(s_sel), .s_we(s_we), .s_dat_o(s_dat_o), .s_cyc(s_cyc), .s_stb(s_stb),
      .s_dat_i(s_dat_i), .s_ack(s_ack), .grant(grant), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_adr = '0; m0_sel = '0; m0_we = 0; m0_dat_i = '0; m0_cyc = 0; m0_stb = 0;
      m1_adr = '0; m1_sel = '0; m1_we = 0; m1_dat_i = '0; m1_cyc = 0; m1_stb = 0;
      s_dat_i = '0; s_ack = 0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_b = 0;
      m0_adr = '0; m0_sel = '0; m0_we = 0; m0_dat_i = '0; m0_cyc = 0; m0_stb = 0;
      m1_adr = '0; m1_sel = '0; m1_we = 0; m1_dat_i = '0; m1_cyc = 0; m1_stb = 0;
      s_dat_i = '0; s_ack = 0;
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant got %b want 00", grant); end
      n_checks++; if (s_cyc !== 1'b0) begin n_errors++; $display("FAIL reset_s_cyc got %b want 0", s_cyc); end
      n_checks++; if (err_count !== 8'd0) begin n_errors++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
      tick();
      rst_b = 1; m0_cyc = 1; m0_adr = 32'h0000_1234;
      @(negedge clk);
      n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL req_cycle_grant got %b want 00", grant); end
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL first_grant got %b want 01", grant); end
      n_checks++; if (s_cyc !== 1'b1) begin n_errors++; $display("FAIL first_s_cyc got %b want 1", s_cyc); end
      n_checks++; if (s_adr !== 32'h0000_1234) begin n_errors++; $display("FAIL first_s_adr got %h want 00001234", s_adr); end
      idle_all();
   endtask

   task automatic test_contention();
      logic [1:0] exp_seq [3];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
      rst_b = 0;
      tick();
      rst_b = 1; m0_cyc = 1; m1_cyc = 1;
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL contend_first got %b want 01", grant); end
      tick();
      m0_cyc = 0;
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL handover got %b want 10", grant); end
      m1_cyc = 0;
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL release_idle got %b want 00", grant); end
      for (int i = 0; i < 3; i++) begin
         m0_cyc = 1; m1_cyc = 1;
         tick();
         @(negedge clk);
         n_checks++;
         if (grant !== exp_seq[i]) begin
            n_errors++; $display("FAIL alternate_%0d got %b want %b", i, grant, exp_seq[i]);
         end
         tick();
         m0_cyc = 0; m1_cyc = 0;
         tick();
      end
      idle_all();
   endtask

   task automatic test_atomic_hold();
      m0_cyc = 1;
      tick();
      m1_cyc = 1; s_ack = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL hold_grant_%0d got %b want 01", i, grant); end
         n_checks++; if (m1_ack !== 1'b0) begin n_errors++; $display("FAIL hold_m1_ack_%0d got %b want 0", i, m1_ack); end
         tick();
      end
      s_ack = 0; m0_cyc = 0;
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL hold_handover got %b want 10", grant); end
   endtask

   task automatic test_ack_routing();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0BAD;
      m1_stb = 1; m1_adr = 32'h1000_0040; m1_sel = 4'b1111; m1_we = 0;
      s_dat_i = 32'hDEADBEEF; s_ack = 1;
      @(negedge clk);
      n_checks++; if (m1_ack !== 1'b1) begin n_errors++; $display("FAIL route_m1_ack got %b want 1", m1_ack); end
      n_checks++; if (m0_ack !== 1'b0) begin n_errors++; $display("FAIL route_m0_ack got %b want 0", m0_ack); end
      n_checks++; if (m1_dat_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL route_m1_dat got %h want deadbeef", m1_dat_o); end
      n_checks++; if (s_adr !== 32'h1000_0040) begin n_errors++; $display("FAIL route_s_adr got %h want 10000040", s_adr); end
      tick();
      m1_we = 1; m1_dat_i = 32'hCAFE_F00D; m1_sel = 4'b0011;
      @(negedge clk);
      n_checks++; if (s_we !== 1'b1) begin n_errors++; $display("FAIL route_s_we got %b want 1", s_we); end
      n_checks++; if (s_dat_o !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL route_s_dat_o got %h want cafef00d", s_dat_o); end
      n_checks++; if (s_sel !== 4'b0011) begin n_errors++; $display("FAIL route_s_sel got %b want 0011", s_sel); end
      idle_all();
      s_ack = 1;
      @(negedge clk);
      n_checks++; if ({m1_ack, m0_ack} !== 2'b00) begin n_errors++; $display("FAIL idle_ack got %b want 00", {m1_ack, m0_ack}); end
      n_checks++; if (s_stb !== 1'b0) begin n_errors++; $display("FAIL idle_s_stb got %b want 0", s_stb); end
      idle_all();
   endtask

   task automatic test_timeout();
      m0_cyc = 1;
      tick();
      m0_stb = 1; s_ack = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         n_checks++; if (m0_err !== (i == 5)) begin n_errors++; $display("FAIL tmo_err_%0d got %b want %b", i, m0_err, (i == 5)); end
         n_checks++; if (s_stb !== (i != 5)) begin n_errors++; $display("FAIL tmo_stb_%0d got %b want %b", i, s_stb, (i != 5)); end
         tick();
      end
      @(negedge clk);
      n_checks++; if (err_count !== 8'd1) begin n_errors++; $display("FAIL tmo_count got %0d want 1", err_count); end
      n_checks++; if (m0_err !== 1'b0) begin n_errors++; $display("FAIL tmo_after got %b want 0", m0_err); end
      repeat (4) tick();
      s_ack = 1;
      @(negedge clk);
      n_checks++; if (m0_err !== 1'b0) begin n_errors++; $display("FAIL ackwins_err got %b want 0", m0_err); end
      n_checks++; if (m0_ack !== 1'b1) begin n_errors++; $display("FAIL ackwins_ack got %b want 1", m0_ack); end
      n_checks++; if (s_stb !== 1'b1) begin n_errors++; $display("FAIL ackwins_stb got %b want 1", s_stb); end
      tick();
      s_ack = 0;
      @(negedge clk);
      n_checks++; if (err_count !== 8'd1) begin n_errors++; $display("FAIL ackwins_count got %0d want 1", err_count); end
      repeat (1500) tick();
      @(negedge clk);
      n_checks++; if (err_count !== 8'd255) begin n_errors++; $display("FAIL tmo_saturate got %0d want 255", err_count); end
      idle_all();
   endtask

   task automatic test_reset_mid();
      m1_cyc = 1; m1_stb = 1; s_ack = 0;
      tick();
      @(negedge clk);
      n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL mid_grant got %b want 10", grant); end
      tick();
      tick();
      rst_b = 0;
      @(negedge clk);
      n_checks++; if (m1_err !== 1'b0) begin n_errors++; $display("FAIL mid_err_pre got %b want 0", m1_err); end
      tick();
      @(negedge clk);
      n_checks++; if ({s_cyc, s_stb} !== 2'b00) begin n_errors++; $display("FAIL mid_s_cyc_stb got %b want 00", {s_cyc, s_stb}); end
      n_checks++; if (m1_err !== 1'b0) begin n_errors++; $display("FAIL mid_err_post got %b want 0", m1_err); end
      n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL mid_grant_rst got %b want 00", grant); end
      n_checks++; if (err_count !== 8'd0) begin n_errors++; $display("FAIL mid_errcnt got %0d want 0", err_count); end
      tick();
      rst_b = 1;
      tick();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         n_checks++; if (m1_err !== (i == 5)) begin n_errors++; $display("FAIL mid_wdog_%0d got %b want %b", i, m1_err, (i == 5)); end
         tick();
      end
      idle_all();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_atomic_hold();
      test_ack_routing();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
